// File: rtl/sens_transmitter_pkg.sv
// sens_transmitter_pkg: constants and types shared by the sensor transmit and receive paths
package sens_transmitter_pkg;
  localparam int DEF_OVERSAMPLE = 16;
  localparam int DEF_SAT_MAX = 99;
  localparam logic [7:0] ASCII_R = 8'd82;
  localparam logic [7:0] ASCII_CR = 8'd13;
  localparam logic [7:0] ASCII_ZERO = 8'd48;
  typedef enum logic [1:0] {SEQ_IDLE, SEQ_LOAD, SEQ_SEND} seq_state_e;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  // compare chain instead of a divider: {tens, units} of a value 0..99
  function automatic logic [7:0] split_digits(logic [6:0] s);
    logic [3:0] t;
    t = 4'd0;
    for (int i = 1; i <= 9; i++) if (s >= 7'(10 * i)) t = 4'(i);
    return {t, 4'(s - 7'(t) * 7'd10)};
  endfunction
endpackage

// File: rtl/sens_transmitter_if.sv
// sens_transmitter_if: request/status/serial-line bundle of the sensor transmitter
interface sens_transmitter_if;
  logic [15:0] sens_data_i;
  logic sens_send_i;
  logic sens_busy_o;
  logic sens_done_o;
  logic sens_out_o;
  modport master (output sens_data_i, sens_send_i, input sens_busy_o, sens_done_o, sens_out_o);
  modport slave (input sens_data_i, sens_send_i, output sens_busy_o, sens_done_o, sens_out_o);
endinterface

// File: rtl/sens_transmitter_uart_tx.sv
// sens_uart_tx: 8N1 LSB-first byte serialiser on a non-inverted line, timed by a 16x clock enable
module sens_uart_tx
  import sens_transmitter_pkg::*;
#(
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en_i,
  input  logic       start_i,
  input  logic [7:0] byte_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       tx_o
);
  localparam int CW = $clog2(OVERSAMPLE);
  tx_state_e state_q;
  logic [CW-1:0] tick_q;
  logic [2:0] bit_q;
  logic [7:0] sh_q;
  logic tx_q, done_q, bit_end;
  assign bit_end = clk_en_i && tick_q == CW'(OVERSAMPLE - 1);
  assign busy_o = state_q != TX_IDLE;
  assign done_o = done_q;
  assign tx_o = tx_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= TX_IDLE;
      tick_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      tx_q <= 1'b1;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (clk_en_i && state_q != TX_IDLE) tick_q <= bit_end ? '0 : tick_q + 1'b1;
      case (state_q)
        TX_IDLE: if (start_i) begin
          state_q <= TX_START;
          sh_q <= byte_i;
          tick_q <= '0;
          tx_q <= 1'b0;
        end
        TX_START: if (bit_end) begin
          state_q <= TX_DATA;
          bit_q <= '0;
          tx_q <= sh_q[0];
        end
        TX_DATA: if (bit_end) begin
          sh_q <= sh_q >> 1;
          bit_q <= bit_q + 1'b1;
          tx_q <= bit_q == 3'd7 ? 1'b1 : sh_q[1];
          state_q <= bit_q == 3'd7 ? TX_STOP : TX_DATA;
        end
        TX_STOP: if (bit_end) begin
          state_q <= TX_IDLE;
          done_q <= 1'b1;
        end
        default: state_q <= TX_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/sens_transmitter.sv
// sens_transmitter: serialises 'R', tens, units, CR for a saturated distance on an inverted 8N1 line
module sens_transmitter
  import sens_transmitter_pkg::*;
#(
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int SAT_MAX = DEF_SAT_MAX
) (
  input logic clk_in_i,
  input logic reset_i,
  input logic clk_en_i,
  sens_transmitter_if.slave bus
);
  seq_state_e state_q;
  logic [1:0] idx_q;
  logic [3:0] tens_q, units_q;
  logic busy_q, done_q;
  logic [6:0] sat;
  logic [7:0] digits, tx_byte;
  logic accept, tx_busy, tx_done, tx_line;
  assign sat = bus.sens_data_i > 16'(SAT_MAX) ? 7'(SAT_MAX) : bus.sens_data_i[6:0];
  assign digits = split_digits(sat);
  // a request in the done cycle is dropped so the next frame starts a cycle after busy falls
  assign accept = bus.sens_send_i && !busy_q && !done_q;
  assign tx_byte = idx_q == 2'd0 ? ASCII_R :
                   idx_q == 2'd1 ? ASCII_ZERO + {4'd0, tens_q} :
                   idx_q == 2'd2 ? ASCII_ZERO + {4'd0, units_q} : ASCII_CR;
  assign bus.sens_busy_o = busy_q;
  assign bus.sens_done_o = done_q;
  assign bus.sens_out_o = ~tx_line;
  always_ff @(posedge clk_in_i) begin
    if (reset_i) begin
      state_q <= SEQ_IDLE;
      idx_q <= '0;
      tens_q <= '0;
      units_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        SEQ_IDLE: if (accept) begin
          state_q <= SEQ_LOAD;
          busy_q <= 1'b1;
          idx_q <= '0;
          {tens_q, units_q} <= digits;
        end
        SEQ_LOAD: if (!tx_busy) state_q <= SEQ_SEND;
        SEQ_SEND: if (tx_done) begin
          idx_q <= idx_q + 1'b1;
          state_q <= idx_q == 2'd3 ? SEQ_IDLE : SEQ_LOAD;
          busy_q <= idx_q != 2'd3;
          done_q <= idx_q == 2'd3;
        end
        default: state_q <= SEQ_IDLE;
      endcase
    end
  end
  sens_uart_tx #(.OVERSAMPLE(OVERSAMPLE)) u_tx (
    .clk(clk_in_i),
    .rst(reset_i),
    .clk_en_i(clk_en_i),
    .start_i(state_q == SEQ_LOAD && !tx_busy),
    .byte_i(tx_byte),
    .busy_o(tx_busy),
    .done_o(tx_done),
    .tx_o(tx_line)
  );
endmodule
